// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter splitting address-stream requests into memory beats.
// Define META_PRIORITY_EN to give requester 0 fixed priority in IDLE.
module mem_req_arbiter #(
  parameter int N_REQ     = 2,
  parameter int BW        = 128,
  parameter int DATA_SIZE = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic [N_REQ-1:0]      req_valid_i,
  input  logic [N_REQ*48-1:0]   req_data_i,
  output logic [N_REQ-1:0]      req_ready_o,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic [31:0]           mem_addr_o,
  output logic [15:0]           mem_nelem_o,
  output logic [(N_REQ > 1 ? $clog2(N_REQ) : 1)-1:0] mem_src_o,
  output logic                  busy_o
);

  localparam int MAX_ELEMS =
    (BW / DATA_SIZE) < 1 ? 1 : BW / DATA_SIZE;
  localparam int ELEM_BYTES_LOG = $clog2(DATA_SIZE / 8);
  localparam int SRC_W = N_REQ > 1 ? $clog2(N_REQ) : 1;
  localparam logic [15:0] MAX_N = 16'(MAX_ELEMS);
  localparam logic [SRC_W-1:0] LAST = SRC_W'(N_REQ - 1);

  typedef enum logic {
    IDLE,
    ISSUE
  } state_e;

  state_e            state_q, state_d;
  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [15:0]       rem_q, rem_d;
  logic [31:0]       addr_q, addr_d;
  logic [SRC_W-1:0]  src_q, src_d;

  logic              found;
  logic [SRC_W-1:0]  grant;
  logic [47:0]       sel;
  logic [15:0]       nelem;

  function automatic logic [SRC_W-1:0] wrap_inc(
    input logic [SRC_W-1:0] i
  );
    return (i == LAST) ? '0 : i + SRC_W'(1);
  endfunction

  // First pass: at/after rr_ptr; second pass wraps to the lowest index.
  always_comb begin
    found = 1'b0;
    grant = '0;
    sel   = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && req_valid_i[j] &&
          SRC_W'(j) >= rr_ptr_q) begin
        found = 1'b1;
        grant = SRC_W'(j);
        sel   = req_data_i[j*48 +: 48];
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && req_valid_i[j]) begin
        found = 1'b1;
        grant = SRC_W'(j);
        sel   = req_data_i[j*48 +: 48];
      end
    end
`ifdef META_PRIORITY_EN
    if (req_valid_i[0]) begin
      found = 1'b1;
      grant = '0;
      sel   = req_data_i[47:0];
    end
`else
`endif
  end

  assign nelem = (rem_q > MAX_N) ? MAX_N : rem_q;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    rem_d    = rem_q;
    addr_d   = addr_q;
    src_d    = src_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          rem_d  = sel[47:32];
          addr_d = sel[31:0];
          src_d  = grant;
          if (sel[47:32] == 16'd0) begin
            rr_ptr_d = wrap_inc(grant);
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (mem_ready_i) begin
          rem_d  = rem_q - nelem;
          addr_d = addr_q +
                   (32'(nelem) << ELEM_BYTES_LOG);
          if (rem_d == 16'd0) begin
            state_d  = IDLE;
            rr_ptr_d = wrap_inc(src_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      rem_q    <= '0;
      addr_q   <= '0;
      src_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      rem_q    <= rem_d;
      addr_q   <= addr_d;
      src_q    <= src_d;
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (state_q == IDLE && found) begin
      req_ready_o[grant] = 1'b1;
    end
  end

  assign mem_valid_o = (state_q == ISSUE);
  assign busy_o      = (state_q == ISSUE);
  assign mem_addr_o  = mem_valid_o ? addr_q : 32'd0;
  assign mem_nelem_o = mem_valid_o ? nelem : 16'd0;
  assign mem_src_o   = src_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: beats, backpressure,
// fairness, zero length, clear and reset mid-burst.
module tb_mem_req_arbiter;

`ifdef META_PRIORITY_EN
  localparam bit META = 1'b1;
`else
  localparam bit META = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        clear_i;
  logic [1:0]  req_valid_i;
  logic [95:0] req_data_i;
  logic [1:0]  req_ready_o;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic [31:0] mem_addr_o;
  logic [15:0] mem_nelem_o;
  logic [0:0]  mem_src_o;
  logic        busy_o;

  logic [47:0] rd0, rd1;
  assign req_data_i = {rd1, rd0};

  always #5 clk_i = ~clk_i;

  mem_req_arbiter dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .mem_valid_o (mem_valid_o),
    .mem_ready_i (mem_ready_i),
    .mem_addr_o  (mem_addr_o),
    .mem_nelem_o (mem_nelem_o),
    .mem_src_o   (mem_src_o),
    .busy_o      (busy_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag,
                          input logic [63:0] obs,
                          input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic beat(input string tag,
                      input logic [31:0] a,
                      input logic [15:0] n,
                      input logic s);
    #1;
    check_eq({tag, ".valid"}, 64'(mem_valid_o), 64'd1);
    check_eq({tag, ".addr"}, 64'(mem_addr_o), 64'(a));
    check_eq({tag, ".nelem"}, 64'(mem_nelem_o), 64'(n));
    check_eq({tag, ".src"}, 64'(mem_src_o), 64'(s));
    check_eq({tag, ".rdy"}, 64'(req_ready_o), 64'd0);
    check_eq({tag, ".busy"}, 64'(busy_o), 64'd1);
  endtask

  task automatic idle_chk(input string tag);
    #1;
    check_eq({tag, ".valid"}, 64'(mem_valid_o), 64'd0);
    check_eq({tag, ".busy"}, 64'(busy_o), 64'd0);
  endtask

  task automatic rdy_chk(input string tag,
                         input logic [1:0] exp);
    #1;
    check_eq(tag, 64'(req_ready_o), 64'(exp));
  endtask

  logic [0:0] fair_src [4];

  initial begin
    rst_i       = 1'b1;
    clear_i     = 1'b0;
    req_valid_i = 2'b00;
    rd0         = '0;
    rd1         = '0;
    mem_ready_i = 1'b0;
    tick();
    tick();
    #1;
    check_eq("rst.valid", 64'(mem_valid_o), 64'd0);
    check_eq("rst.addr", 64'(mem_addr_o), 64'd0);
    check_eq("rst.nelem", 64'(mem_nelem_o), 64'd0);
    check_eq("rst.src", 64'(mem_src_o), 64'd0);
    check_eq("rst.busy", 64'(busy_o), 64'd0);
    check_eq("rst.rdy", 64'(req_ready_o), 64'd0);
    rst_i = 1'b0;

    // single request, len 10
    rd0 = {16'd10, 32'h1000};
    req_valid_i = 2'b01;
    mem_ready_i = 1'b1;
    rdy_chk("t1.grant", 2'b01);
    tick();
    req_valid_i = 2'b00;
    beat("t1.b0", 32'h1000, 16'd4, 1'b0);
    tick();
    beat("t1.b1", 32'h1010, 16'd4, 1'b0);
    tick();
    beat("t1.b2", 32'h1020, 16'd2, 1'b0);
    tick();
    idle_chk("t1.done");
    rd1 = {16'd4, 32'h9000};
    req_valid_i = 2'b11;
    rdy_chk("t1.rrptr", META ? 2'b01 : 2'b10);
    req_valid_i = 2'b00;

    // backpressure on second beat
    rd0 = {16'd10, 32'h1000};
    req_valid_i = 2'b01;
    rdy_chk("t2.grant", 2'b01);
    tick();
    req_valid_i = 2'b00;
    beat("t2.b0", 32'h1000, 16'd4, 1'b0);
    tick();
    mem_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      beat("t2.hold", 32'h1010, 16'd4, 1'b0);
      tick();
    end
    beat("t2.b1", 32'h1010, 16'd4, 1'b0);
    mem_ready_i = 1'b1;
    tick();
    beat("t2.b2", 32'h1020, 16'd2, 1'b0);
    tick();
    idle_chk("t2.done");

    // zero length on requester 1
    rd1 = {16'd0, 32'h2000};
    req_valid_i = 2'b10;
    rdy_chk("t3.grant", 2'b10);
    tick();
    req_valid_i = 2'b00;
    idle_chk("t3.nobeat");
    req_valid_i = 2'b11;
    rdy_chk("t3.rrptr", 2'b01);
    req_valid_i = 2'b00;

    // fairness, both always valid
    fair_src[0] = 1'b0;
    fair_src[1] = META ? 1'b0 : 1'b1;
    fair_src[2] = 1'b0;
    fair_src[3] = META ? 1'b0 : 1'b1;
    rd0 = {16'd4, 32'h3000};
    rd1 = {16'd4, 32'h4000};
    req_valid_i = 2'b11;
    for (int g = 0; g < 4; g++) begin
      rdy_chk($sformatf("t4.grant%0d", g),
              fair_src[g] ? 2'b10 : 2'b01);
      tick();
      beat($sformatf("t4.beat%0d", g),
           fair_src[g] ? 32'h4000 : 32'h3000,
           16'd4, fair_src[g]);
      tick();
    end
    req_valid_i = 2'b00;
    idle_chk("t4.done");

    // clear mid-burst, len 12
    rd0 = {16'd12, 32'h5000};
    req_valid_i = 2'b01;
    rdy_chk("t5.grant", 2'b01);
    tick();
    req_valid_i = 2'b00;
    beat("t5.b0", 32'h5000, 16'd4, 1'b0);
    tick();
    beat("t5.b1", 32'h5010, 16'd4, 1'b0);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    idle_chk("t5.clr");
    check_eq("t5.addr", 64'(mem_addr_o), 64'd0);
    check_eq("t5.nelem", 64'(mem_nelem_o), 64'd0);
    check_eq("t5.src", 64'(mem_src_o), 64'd0);
    req_valid_i = 2'b11;
    rdy_chk("t5.rrptr", 2'b01);
    req_valid_i = 2'b00;
    for (int k = 0; k < 3; k++) begin
      tick();
      idle_chk($sformatf("t5.quiet%0d", k));
    end

    // reset mid-burst on requester 1
    rd1 = {16'd8, 32'h6000};
    req_valid_i = 2'b10;
    rdy_chk("t6.grant", 2'b10);
    tick();
    req_valid_i = 2'b00;
    beat("t6.b0", 32'h6000, 16'd4, 1'b1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    idle_chk("t6.rst");
    check_eq("t6.src", 64'(mem_src_o), 64'd0);
    tick();
    idle_chk("t6.quiet");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
